// File: rtl/otp_ctrl_pkg.sv
// Shared widths, state encoding and default timing for the OTP macro controller.
// Optional feature macro: OTP_CTRL_VERIFY_EN (adds read-back verify after programming).
package otp_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TM_W   = 2;
  localparam int TMR_W  = 8;

  localparam int T_SU_DEF  = 2;
  localparam int T_RD_DEF  = 4;
  localparam int T_PGM_DEF = 8;
  localparam int T_HD_DEF  = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD,
    ST_PGM,
    ST_HOLD,
`ifdef OTP_CTRL_VERIFY_EN
    ST_VSETUP,
    ST_VRD,
    ST_VHOLD,
`endif
    ST_DONE
  } state_e;

  // A timed state lasting N cycles loads N-1; the timer reports done on its last cycle.
  function automatic logic [TMR_W-1:0] ld_cnt(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/otp_ctrl_if.sv
// Host request/response bundle for otp_ctrl.
interface otp_ctrl_if;
  import otp_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TM_W-1:0]   req_tm;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_tm,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_tm,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/otp_ctrl_timer.sv
// Loadable down-counter shared by every timed state of the controller.
module otp_ctrl_timer
  import otp_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q;

  // Load on state entry, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/otp_ctrl.sv
// OTP macro sequencer: read and program cycles with setup/strobe/hold timing.
// Optional macro OTP_CTRL_VERIFY_EN appends a read-back verify to non-zero writes.
//
// state   | meaning
// IDLE    | ready for a host request
// SETUP   | address/data settle before a strobe
// RD      | PRD strobe, data captured on the last cycle
// PGM     | PWE program pulse
// HOLD    | address/data held after the strobe
// VSETUP  | verify: settle before read-back (PPROG off)
// VRD     | verify: PRD strobe, compare on the last cycle
// VHOLD   | verify: hold after read-back
// DONE    | one-cycle response
module otp_ctrl
  import otp_ctrl_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_RD  = T_RD_DEF,
  parameter int T_PGM = T_PGM_DEF,
  parameter int T_HD  = T_HD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  otp_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] PA,
  output logic [DATA_W-1:0] PDIN,
  output logic              PRD,
  output logic              PPROG,
  output logic              PWE,
  output logic [TM_W-1:0]   PTM,
  input  logic [DATA_W-1:0] PDOB
);

  if (T_SU < 1 || T_SU > 255) begin : g_bad_t_su
    $error("otp_ctrl: T_SU=%0d outside legal range 1..255", T_SU);
  end
  if (T_RD < 1 || T_RD > 255 || T_PGM < 1 || T_PGM > 255 || T_HD < 1 || T_HD > 255) begin : g_bad_t
    $error("otp_ctrl: T_RD/T_PGM/T_HD outside legal range 1..255");
  end

  localparam logic [TMR_W-1:0] SU_LD  = ld_cnt(T_SU);
  localparam logic [TMR_W-1:0] RD_LD  = ld_cnt(T_RD);
  localparam logic [TMR_W-1:0] PGM_LD = ld_cnt(T_PGM);
  localparam logic [TMR_W-1:0] HD_LD  = ld_cnt(T_HD);

  state_e            state_q, state_d;
  logic              ready_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TM_W-1:0]   tm_q;
  logic [DATA_W-1:0] rdata_q;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              accept;
  logic              active;

  // ready_q is only ever set in IDLE, so it doubles as the accept qualifier.
  assign accept = bus.req_valid && ready_q;

  otp_ctrl_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // State register; ready is registered so it stays low through reset and rises one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Next-state and timer load; the timer is loaded on the edge that enters a timed state.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_write && (bus.req_wdata == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SU_LD;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (write_q) begin
            state_d = ST_PGM;
            tmr_val = PGM_LD;
          end else begin
            state_d = ST_RD;
            tmr_val = RD_LD;
          end
        end
      end
      ST_RD, ST_PGM: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
`ifdef OTP_CTRL_VERIFY_EN
          if (write_q) begin
            state_d  = ST_VSETUP;
            tmr_load = 1'b1;
            tmr_val  = SU_LD;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef OTP_CTRL_VERIFY_EN
      ST_VSETUP: begin
        if (tmr_done) begin
          state_d  = ST_VRD;
          tmr_load = 1'b1;
          tmr_val  = RD_LD;
        end
      end
      ST_VRD: begin
        if (tmr_done) begin
          state_d  = ST_VHOLD;
          tmr_load = 1'b1;
          tmr_val  = HD_LD;
        end
      end
      ST_VHOLD: begin
        if (tmr_done) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are latched on accept so the host may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tm_q    <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      tm_q    <= bus.req_tm;
    end
  end

  // Read data is captured on the last strobe cycle and held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (tmr_done && (state_q == ST_RD
`ifdef OTP_CTRL_VERIFY_EN
                              || state_q == ST_VRD
`endif
                              )) begin
      rdata_q <= PDOB;
    end
  end

`ifdef OTP_CTRL_VERIFY_EN
  logic err_q;

  // Any requested burn that did not read back as 1 is a verify failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == ST_VRD && tmr_done) begin
      err_q <= |(wdata_q & ~PDOB);
    end
  end

  assign bus.rsp_err = (state_q == ST_DONE) && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_rdata = rdata_q;

  // Macro controls decode from state only, so reset forces them low without a clock.
  always_comb begin
    active = (state_q != ST_IDLE) && (state_q != ST_DONE);
    PA     = active ? addr_q : '0;
    PTM    = active ? tm_q : '0;
    PDIN   = (active && write_q) ? wdata_q : '0;
    PWE    = (state_q == ST_PGM);
    PPROG  = write_q && ((state_q == ST_SETUP) || (state_q == ST_PGM) || (state_q == ST_HOLD));
    PRD    = (state_q == ST_RD);
`ifdef OTP_CTRL_VERIFY_EN
    if (state_q == ST_VRD) PRD = 1'b1;
`endif
  end

endmodule

// File: tb/tb_otp_ctrl.sv
// Directed bench for otp_ctrl with a simple OTP array model behind PA/PDOB.
module tb_otp_ctrl;

`ifdef OTP_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int WR_LAT  = VERIFY ? 21 : 13;
  localparam int WR_PRD  = VERIFY ? 4 : 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otp_ctrl_if bus ();
  logic [6:0] PA;
  logic [7:0] PDIN, PDOB;
  logic       PRD, PPROG, PWE;
  logic [1:0] PTM;

  otp_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .PA    (PA),
    .PDIN  (PDIN),
    .PRD   (PRD),
    .PPROG (PPROG),
    .PWE   (PWE),
    .PTM   (PTM),
    .PDOB  (PDOB)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [128];
  logic [7:0] burn_mask = 8'hFF;
  logic [7:0] exp_rd;

  assign PDOB = mem[PA];

  always @(posedge clk) if (PWE) mem[PA] <= mem[PA] | (PDIN & burn_mask);

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(PRD && PWE)) else begin
        failures++;
        $display("FAIL prd_pwe_excl PRD=%b PWE=%b required not both 1", PRD, PWE);
      end
      assert (!(PWE && !PPROG)) else begin
        failures++;
        $display("FAIL pwe_envelope PWE=%b PPROG=%b required PPROG=1", PWE, PPROG);
      end
    end
  end

  // Issues one request and measures it cycle by cycle until rsp_valid (bounded).
  task automatic do_req(input logic wr, input logic [6:0] a, input logic [7:0] d,
                        input logic [1:0] tm, output int lat, output int nprd,
                        output int npwe, output int npprog, output int nbad);
    lat = -1; nprd = 0; npwe = 0; npprog = 0; nbad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = d; bus.req_tm = tm;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_addr = ~a;
        bus.req_wdata = ~d; bus.req_tm = ~tm;
      end
      if (PRD) nprd++;
      if (PWE) npwe++;
      if (PPROG) npprog++;
      if (bus.req_ready) nbad++;
      if (bus.rsp_valid) begin
        lat = n;
        if (PA !== 7'd0 || PDIN !== 8'd0 || PTM !== 2'd0) nbad++;
        break;
      end else if (PA !== a || PTM !== tm || PDIN !== (wr ? d : 8'd0)) begin
        nbad++;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp got valid=%b err=%b exp=0", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", bus.rsp_rdata); end
    checks++; if ({PA, PDIN, PRD, PPROG, PWE, PTM} !== 20'd0) begin failures++; $display("FAIL rst_macro got=%h exp=0", {PA, PDIN, PRD, PPROG, PWE, PTM}); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rel_ready_early got=%b exp=0", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_read(input logic [6:0] a, input logic [1:0] tm, input logic [7:0] exp);
    int lat, nprd, npwe, npprog, nbad;
    do_req(1'b0, a, 8'h00, tm, lat, nprd, npwe, npprog, nbad);
    checks++; if (lat !== 9) begin failures++; $display("FAIL rd_lat a=%h got=%0d exp=9", a, lat); end
    checks++; if (nprd !== 4) begin failures++; $display("FAIL rd_prd_cycles got=%0d exp=4", nprd); end
    checks++; if (npwe !== 0 || npprog !== 0) begin failures++; $display("FAIL rd_pgm_activity got pwe=%0d pprog=%0d exp=0", npwe, npprog); end
    checks++; if (nbad !== 0) begin failures++; $display("FAIL rd_bus_hold got=%0d bad cycles exp=0", nbad); end
    checks++; if (bus.rsp_rdata !== exp) begin failures++; $display("FAIL rd_data got=%h exp=%h", bus.rsp_rdata, exp); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", bus.rsp_err); end
    exp_rd = exp;
  endtask

  task automatic test_write();
    int lat, nprd, npwe, npprog, nbad;
    do_req(1'b1, 7'h7F, 8'h3C, 2'b11, lat, nprd, npwe, npprog, nbad);
    if (VERIFY) exp_rd = 8'h3C;
    checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL wr_lat got=%0d exp=%0d", lat, WR_LAT); end
    checks++; if (npprog !== 12) begin failures++; $display("FAIL wr_pprog_cycles got=%0d exp=12", npprog); end
    checks++; if (npwe !== 8) begin failures++; $display("FAIL wr_pwe_cycles got=%0d exp=8", npwe); end
    checks++; if (nprd !== WR_PRD) begin failures++; $display("FAIL wr_prd_cycles got=%0d exp=%0d", nprd, WR_PRD); end
    checks++; if (nbad !== 0) begin failures++; $display("FAIL wr_bus_hold got=%0d bad cycles exp=0", nbad); end
    checks++; if (bus.rsp_rdata !== exp_rd || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL wr_rsp got rdata=%h err=%b exp rdata=%h err=0", bus.rsp_rdata, bus.rsp_err, exp_rd); end
  endtask

  task automatic test_zero_write();
    int lat, nprd, npwe, npprog, nbad;
    do_req(1'b1, 7'h11, 8'h00, 2'b01, lat, nprd, npwe, npprog, nbad);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zw_lat got=%0d exp=1", lat); end
    checks++; if (npwe !== 0 || npprog !== 0 || nprd !== 0) begin failures++; $display("FAIL zw_activity got pwe=%0d pprog=%0d prd=%0d exp=0", npwe, npprog, nprd); end
    checks++; if (nbad !== 0 || bus.rsp_rdata !== exp_rd) begin failures++; $display("FAIL zw_rsp got bad=%0d rdata=%h exp bad=0 rdata=%h", nbad, bus.rsp_rdata, exp_rd); end
  endtask

`ifdef OTP_CTRL_VERIFY_EN
  task automatic test_verify();
    int lat, nprd, npwe, npprog, nbad;
    burn_mask = 8'h0C;
    do_req(1'b1, 7'h10, 8'h3C, 2'b00, lat, nprd, npwe, npprog, nbad);
    checks++; if (lat !== 21) begin failures++; $display("FAIL vf_lat got=%0d exp=21", lat); end
    checks++; if (bus.rsp_rdata !== 8'h0C) begin failures++; $display("FAIL vf_rdata got=%h exp=0c", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b1) begin failures++; $display("FAIL vf_err got=%b exp=1", bus.rsp_err); end
    checks++; if (npprog !== 12 || nprd !== 4 || nbad !== 0) begin failures++; $display("FAIL vf_shape got pprog=%0d prd=%0d bad=%0d exp 12/4/0", npprog, nprd, nbad); end
    burn_mask = 8'hFF;
  endtask
`endif

  task automatic test_back_to_back();
    int pulses, p1, p2, nbad;
    pulses = 0; p1 = -1; p2 = -1; nbad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 7'h05;
    bus.req_wdata = 8'h00; bus.req_tm = 2'b00;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 11) bus.req_valid = 1'b0;
      if (n == 10 && bus.req_ready !== 1'b1) nbad++;
      if (n == 9 && bus.req_ready !== 1'b0) nbad++;
      if (bus.rsp_valid) begin
        pulses++;
        if (p1 < 0) p1 = n; else p2 = n;
      end
    end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++; if (p1 !== 9 || p2 !== 19) begin failures++; $display("FAIL b2b_timing got=%0d,%0d exp=9,19", p1, p2); end
    checks++; if (nbad !== 0 || bus.rsp_rdata !== 8'hA5) begin failures++; $display("FAIL b2b_ready_data got bad=%0d rdata=%h exp bad=0 rdata=a5", nbad, bus.rsp_rdata); end
  endtask

  task automatic test_reset_pgm();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h40;
    bus.req_wdata = 8'hFF; bus.req_tm = 2'b10;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid = 1'b0;
    end
    checks++; if (PWE !== 1'b1 || PPROG !== 1'b1 || PA !== 7'h40) begin failures++; $display("FAIL rp_pre got pwe=%b pprog=%b pa=%h exp 1/1/40", PWE, PPROG, PA); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (PWE !== 1'b0 || PPROG !== 1'b0 || PA !== 7'h00 || PDIN !== 8'h00) begin failures++; $display("FAIL rp_async got pwe=%b pprog=%b pa=%h pdin=%h exp 0", PWE, PPROG, PA, PDIN); end
    checks++; if (bus.rsp_rdata !== 8'h00 || bus.req_ready !== 1'b0) begin failures++; $display("FAIL rp_regs got rdata=%h ready=%b exp 00/0", bus.rsp_rdata, bus.req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rp_ready_early got=%b exp=0", bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || PPROG !== 1'b0) begin failures++; $display("FAIL rp_ready got ready=%b pprog=%b exp 1/0", bus.req_ready, PPROG); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h05] = 8'hA5;
    mem[7'h22] = 8'h5A;
    exp_rd = 8'h00;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_tm = '0;
    test_reset();
    test_read(7'h05, 2'b10, 8'hA5);
    test_read(7'h22, 2'b01, 8'h5A);
    test_write();
    test_zero_write();
`ifdef OTP_CTRL_VERIFY_EN
    test_verify();
    test_read(7'h05, 2'b00, 8'hA5);
`endif
    test_back_to_back();
    test_reset_pgm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/otp_ctrl.md
OTP_CTRL -- requirements
Module: otp_ctrl

Interface
REQ-001 Parameter T_SU, default 2: address/data setup cycles before any PRD or PWE assertion. Legal range 1..255; a simulation assertion SHALL flag values outside it.
REQ-002 Parameter T_RD, default 4: PRD high cycles per read.
REQ-003 Parameter T_PGM, default 8: PWE high cycles per program pulse.
REQ-004 Parameter T_HD, default 2: hold cycles after PRD or PWE falls.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid / req_ready  in / out  1 / 1  host request handshake.
REQ-008 req_write  in  1  1=program, 0=read.
REQ-009 req_addr  in  7  byte address 0..127.
REQ-010 req_wdata  in  8  bits to program; a 1 means burn.
REQ-011 req_tm  in  2  test mode, sampled at accept.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-014 rsp_err  out  1  verify failure; valid with rsp_valid.
REQ-015 PA  out  7; PDIN  out  8; PRD  out  1; PPROG  out  1; PWE  out  1; PTM  out  2: macro controls.
REQ-016 PDOB  in  8: macro read data.

Function
REQ-017 Accept a request when req_valid && req_ready; req_ready SHALL be 1 only in IDLE, and addr/wdata/write/tm SHALL be latched on accept.
REQ-018 FSM states: IDLE, SETUP, RD, PGM, HOLD, VSETUP, VRD, VHOLD, DONE; every timed state SHALL last exactly its parameter count.
REQ-019 Read path: IDLE->SETUP(T_SU)->RD(T_RD)->HOLD(T_HD)->DONE->IDLE; PRD=1 only in RD; PDOB captured on the last RD cycle.
REQ-020 Write path: IDLE->SETUP->PGM(T_PGM)->HOLD->DONE; PPROG=1 from SETUP through HOLD inclusive; PWE=1 only in PGM.
REQ-021 A write with req_wdata==0 SHALL go IDLE->DONE with no PPROG or PWE activity; rsp_valid asserts on the cycle after accept.
REQ-022 PA, PDIN and PTM SHALL hold latched values from SETUP through the final hold state and SHALL be 0 in IDLE and DONE; PDIN SHALL be 0 on reads.
REQ-023 PRD and PWE SHALL never be high together; PWE SHALL never be high while PPROG is 0.
REQ-024 rsp_valid SHALL be high exactly in DONE. Read latency from the accept cycle k is rsp_valid at k+T_SU+T_RD+T_HD+1; write latency is k+T_SU+T_PGM+T_HD+1.
REQ-025 rsp_rdata SHALL hold its last captured value until the next capture; rsp_err SHALL be 0 except as defined in REQ-029.
REQ-026 A request is accepted no earlier than the cycle after DONE; there is no back-to-back overlap.

Reset
REQ-027 On rst_n low: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all macro outputs=0, asynchronously and including mid-PGM. req_ready SHALL rise the first cycle after rst_n is released.

Configuration
REQ-028 Without OTP_CTRL_VERIFY_EN: the VSETUP, VRD and VHOLD states are absent and rsp_err is tied to 0.
REQ-029 With OTP_CTRL_VERIFY_EN: a non-zero write continues HOLD->VSETUP(T_SU)->VRD(T_RD)->VHOLD(T_HD)->DONE with PPROG=0 and PRD=1 only in VRD. rsp_rdata=PDOB captured in VRD; rsp_err=|(wdata & ~PDOB). Write latency becomes k+2*T_SU+T_PGM+T_RD+2*T_HD+1.

Structure
REQ-030 Package otp_ctrl_pkg SHALL hold ADDR_W=7, DATA_W=8, TM_W=2, the state enum, and the default timing constants.
REQ-031 Sub-module otp_ctrl_timer: 8-bit loadable down-counter with a done flag, used by every timed state.

Verification
REQ-032 Read addr 0x05 with PDOB model returning 0xA5 -> PRD high 4 cycles; rsp_valid at k+9; rsp_rdata=0xA5; PA=0x05 throughout.
REQ-033 Write addr 0x7F, wdata 0x3C -> PPROG high 12 cycles, PWE high 8 cycles; rsp_valid at k+13 (verify off).
REQ-034 Write with wdata 0x00 -> no PPROG or PWE; rsp_valid at k+1.
REQ-035 rst_n pulsed low during PGM cycle 3 -> PWE, PPROG and PA go 0 immediately; req_ready=1 one cycle after release.
REQ-036 OTP_CTRL_VERIFY_EN with the model burning only 0x0C of wdata 0x3C -> rsp_valid at k+21; rsp_rdata=0x0C; rsp_err=1.
REQ-037 req_valid held high continuously -> requests accepted one at a time; PRD/PWE exclusion and the PPROG envelope hold, checked by assertions.
